acs_array: RTL
==============

// Module: acs_array
// PURPOSE
//  Parametrised add-compare-select array for the Viterbi decoder; successor to the fixed 4-state ACS pair.
//  Holds all 2^(K-1) path metrics internally and performs per-step ACS with tie-break, saturation and normalisation.
//  Keeps register-exchange survivor paths of depth D and emits decoded bits. Sits between branch-metric unit and output.
// PARAMETERS
//  K    3  constraint length; NS = 2^(K-1) states; legal K >= 3
//  BMW  4  branch-metric width (bits)
//  PMW  8  path-metric width; legal PMW >= BMW+K
//  D    8  survivor (traceback) depth in steps; legal D >= 2
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  valid_in   in   1          one trellis step presented this cycle
//  start      in   1          with valid_in: first step of a new frame (encoder starts in state 0)
//  bm_in      in   NS*2*BMW   branch metric into state ns from predecessor j at [(ns*2+j)*BMW +: BMW]
//  valid_out  out  1          pm_out/decision/best_state updated for one step
//  pm_out     out  NS*PMW     registered path metrics, state s at [s*PMW +: PMW]
//  decision   out  NS         selected predecessor bit j per state
//  best_state out  K-1        lowest-metric state (see CONFIGURATION)
//  dec_bit    out  1          decoded bit, D steps behind the current step
//  dec_valid  out  1          dec_bit is meaningful
// BEHAVIOUR
//  Reset: pm[0]=0, pm[s!=0]=INIT=2^(PMW-2); survivors, fill counter, all other outputs 0.
//  Trellis: next state = {s[K-3:0],u}; predecessors of ns: p_j = {j, ns[K-2:1]}, j in {0,1}; input bit u = ns[0].
//  Step (valid_in=1): cand_j = pm[p_j] + bm(ns,j), saturating at 2^PMW-1; j=1 chosen only if cand_1 < cand_0 (tie -> 0).
//  start=1: ACS uses the reset pattern as old metrics; survivors zeroed, fill counter cleared before this step.
//  Normalise: if every new metric has MSB set, clear MSB of all in the same cycle (relative order kept).
//  Survivor: sp[ns] <= {sp[p_sel][D-2:0], ns[0]}.
//  Latency: 1 cycle; all outputs registered; valid_out is valid_in delayed one cycle.
//  valid_in=0: all state held, valid_out=0, dec_valid=0; other outputs hold their last values.
//  Fill counter counts steps since start, saturates at D; dec_valid = valid_out && count >= D.
//  dec_bit = sp[best_state][D-1] of the new survivors.
//  rst asserted mid-frame: immediate return to reset values; next valid_in without start runs from reset pattern.
// CONFIGURATION
//  ACS_BEST_STATE_EN defined: combinational min tree over new metrics (lowest index on tie) -> registered best_state.
//    dec_bit is taken from that state.
//  Not defined: no min tree; best_state tied 0; dec_bit taken from sp[0].
// STRUCTURE
//  Shared header viterbi_defs.vh: NS, INIT, predecessor-index function, saturating-add macro.
//    Shared with branch-metric unit and traceback.
//  Sub-module acs_cell: two saturating adders, compare, select.
//    Outputs new metric and decision bit; instantiated NS times via generate.
//  Top holds metric/survivor registers, normalisation, fill counter, optional min tree.
// TESTING (K=3,BMW=4,PMW=8,D=8, macro defined unless noted)
//  Reset: rst 20ns -> pm_out={64,64,64,0} (s3..s0); valid_out, decision, dec_valid, best_state all 0.
//  start+valid_in, all bm=0 -> next cycle valid_out=1, pm_out s0..s3={0,0,64,64}, decision=0000, dec_valid=0.
//  Tie: after start, bm(0,0)=bm(0,1)=2 with pm[0]=pm[2] -> decision[0]=0.
//  Normalise: start then all bm=15 each step.
//    -> step n metrics all 15n (n>=2); step 9 would be 135, outputs 7 in all states.
//  Decode: start then bm=0 into odd ns, 15 into even ns, 8 steps -> best_state=3, dec_valid=1 at step 8, dec_bit=1.
//  Hold/reset: valid_in=0 for 2 cycles -> pm_out unchanged, valid_out=0.
//    rst pulse mid-frame -> reset values, dec_valid=0 until 8 new steps.
//    Macro undefined: best_state=0 always, dec_bit from s0.

Source files
------------

// File: rtl/acs_array_pkg.sv
// Shared trellis helpers for the Viterbi ACS array: state count, initial metric
// and predecessor indexing for a rate-1/2 shift-register trellis.
package acs_array_pkg;

  function automatic int unsigned num_states(input int unsigned k);
    return 32'd1 << (k - 32'd1);
  endfunction

  function automatic int unsigned init_metric(input int unsigned pmw);
    return 32'd1 << (pmw - 32'd2);
  endfunction

  // Predecessor j of next state ns is {j, ns[K-2:1]}
  function automatic int unsigned pred_idx(input int unsigned ns, input int unsigned j,
                                           input int unsigned k);
    return (j << (k - 32'd2)) | (ns >> 1);
  endfunction

endpackage

// File: rtl/acs_array_cell.sv
// One add-compare-select cell: two saturating metric adders, a compare and a select.
// Ties resolve to predecessor 0.
module acs_array_cell
  import acs_array_pkg::*;
#(
  parameter int unsigned BMW = 4,
  parameter int unsigned PMW = 8
) (
  input  logic [PMW-1:0] i_pm0,
  input  logic [PMW-1:0] i_pm1,
  input  logic [BMW-1:0] i_bm0,
  input  logic [BMW-1:0] i_bm1,
  output logic [PMW-1:0] o_pm_c,
  output logic           o_dec_c
);

  logic [PMW:0]   w_sum0;
  logic [PMW:0]   w_sum1;
  logic [PMW-1:0] w_cand0;
  logic [PMW-1:0] w_cand1;

  always_comb begin
    w_sum0  = {1'b0, i_pm0} + (PMW+1)'(i_bm0);
    w_sum1  = {1'b0, i_pm1} + (PMW+1)'(i_bm1);
    w_cand0 = w_sum0[PMW] ? {PMW{1'b1}} : w_sum0[PMW-1:0];
    w_cand1 = w_sum1[PMW] ? {PMW{1'b1}} : w_sum1[PMW-1:0];
    o_dec_c = (w_cand1 < w_cand0);
    o_pm_c  = o_dec_c ? w_cand1 : w_cand0;
  end

endmodule

// File: rtl/acs_array.sv
// Parametrised Viterbi add-compare-select array with register-exchange survivors.
// Define ACS_BEST_STATE_EN to decode from the lowest-metric state instead of state 0.
module acs_array
  import acs_array_pkg::*;
#(
  parameter  int unsigned K   = 3,
  parameter  int unsigned BMW = 4,
  parameter  int unsigned PMW = 8,
  parameter  int unsigned D   = 8,
  localparam int unsigned NS  = num_states(K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                start,
  input  logic [NS*2*BMW-1:0] bm_in,
  output logic                valid_out,
  output logic [NS*PMW-1:0]   pm_out,
  output logic [NS-1:0]       decision,
  output logic [K-2:0]        best_state,
  output logic                dec_bit,
  output logic                dec_valid
);

  localparam int unsigned SW = K - 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam logic [PMW-1:0] INIT = PMW'(init_metric(PMW));

  // Oldest survivor bit is consumed as dec_bit in the step it appears, so only D-1 bits are kept
  logic [PMW-1:0] r_pm [NS];
  logic [D-2:0]   r_sp [NS];
  logic [CW-1:0]  r_cnt;
  logic           r_valid_out;
  logic           r_dec_valid;
  logic           r_dec_bit;
  logic [NS-1:0]  r_decision;

  logic [PMW-1:0] w_pm_old [NS];
  logic [D-2:0]   w_sp_old [NS];
  logic [PMW-1:0] w_pm_acs [NS];
  logic [PMW-1:0] w_pm_new [NS];
  logic [D-1:0]   w_sp_new [NS];
  logic [NS-1:0]  w_dec;
  logic           w_norm;
  logic [CW-1:0]  w_cnt_new;
  logic [SW-1:0]  w_sel_state;
  logic           w_dec_bit;

  // A frame start substitutes the reset metrics and empty survivors as the old state
  always_comb begin
    for (int s = 0; s < int'(NS); s++) begin
      w_pm_old[s] = r_pm[s];
      w_sp_old[s] = r_sp[s];
      if (start) begin
        w_pm_old[s] = (s == 0) ? '0 : INIT;
        w_sp_old[s] = '0;
      end
    end
  end

  for (genvar ns = 0; ns < int'(NS); ns++) begin : g_cell
    localparam int unsigned P0 = pred_idx(ns, 0, K);
    localparam int unsigned P1 = pred_idx(ns, 1, K);

    acs_array_cell #(.BMW(BMW), .PMW(PMW)) u_cell (
      .i_pm0   (w_pm_old[P0]),
      .i_pm1   (w_pm_old[P1]),
      .i_bm0   (bm_in[(ns*2)*BMW +: BMW]),
      .i_bm1   (bm_in[(ns*2+1)*BMW +: BMW]),
      .o_pm_c  (w_pm_acs[ns]),
      .o_dec_c (w_dec[ns])
    );

    assign w_sp_new[ns] = {(w_dec[ns] ? w_sp_old[P1] : w_sp_old[P0]), 1'(ns % 2)};
    assign pm_out[ns*PMW +: PMW] = r_pm[ns];
  end

  // Normalise by dropping the shared MSB once every metric carries it
  always_comb begin
    w_norm = 1'b1;
    for (int s = 0; s < int'(NS); s++) begin
      w_norm = w_norm & w_pm_acs[s][PMW-1];
    end
    for (int s = 0; s < int'(NS); s++) begin
      w_pm_new[s] = w_pm_acs[s];
      if (w_norm) begin
        w_pm_new[s][PMW-1] = 1'b0;
      end
    end
  end

  always_comb begin
    w_cnt_new = start ? '0 : r_cnt;
    if (w_cnt_new < CW'(D)) begin
      w_cnt_new = w_cnt_new + CW'(1);
    end
  end

`ifdef ACS_BEST_STATE_EN
  logic [SW-1:0]  r_best;
  logic [PMW-1:0] w_min;

  // Lowest new metric; strict compare keeps the lowest index on ties
  always_comb begin
    w_sel_state = '0;
    w_min       = w_pm_new[0];
    for (int s = 1; s < int'(NS); s++) begin
      if (w_pm_new[s] < w_min) begin
        w_min       = w_pm_new[s];
        w_sel_state = SW'(s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best <= '0;
    end else if (valid_in) begin
      r_best <= w_sel_state;
    end
  end

  assign best_state = r_best;
`else
  assign w_sel_state = '0;
  assign best_state  = '0;
`endif

  assign w_dec_bit = w_sp_new[w_sel_state][D-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(NS); s++) begin
        r_pm[s] <= (s == 0) ? '0 : INIT;
        r_sp[s] <= '0;
      end
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_bit   <= 1'b0;
      r_decision  <= '0;
    end else begin
      r_valid_out <= valid_in;
      r_dec_valid <= valid_in && (w_cnt_new >= CW'(D));
      if (valid_in) begin
        for (int s = 0; s < int'(NS); s++) begin
          r_pm[s] <= w_pm_new[s];
          r_sp[s] <= w_sp_new[s][D-2:0];
        end
        r_cnt      <= w_cnt_new;
        r_dec_bit  <= w_dec_bit;
        r_decision <= w_dec;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign decision  = r_decision;
  assign dec_bit   = r_dec_bit;
  assign dec_valid = r_dec_valid;

endmodule
